// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin req/gnt between two
// writers, plus a clear sequencer that writes zero to every address.
// Ports: clk, rst (async active-low); req0/addr0/data0/gnt0 and
// req1/addr1/data1/gnt1 requester handshakes; clr_start pulse starts a
// clear, busy flags it; WE3/A3/WD3 are the registered write outputs.
module regfile_wr_arbiter #(
   parameter int DataWidth    = 32,
   parameter int Depth        = 32,
   parameter int Addres_depth = 5,
   parameter bit ZeroGuard    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req0,
   input  logic [Addres_depth-1:0] addr0,
   input  logic [DataWidth-1:0]    data0,
   output logic                    gnt0,
   input  logic                    req1,
   input  logic [Addres_depth-1:0] addr1,
   input  logic [DataWidth-1:0]    data1,
   output logic                    gnt1,
   input  logic                    clr_start,
   output logic                    busy,
   output logic                    WE3,
   output logic [Addres_depth-1:0] A3,
   output logic [DataWidth-1:0]    WD3
);

   typedef enum logic {IDLE, CLEAR} state_e;

   localparam logic [Addres_depth-1:0] LastAddr =
      Addres_depth'(Depth - 1);

   state_e                  state_q, state_d;
   logic                    ptr_q, ptr_d;
   logic [Addres_depth-1:0] cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic [Addres_depth-1:0] a_q, a_d;
   logic [DataWidth-1:0]    wd_q, wd_d;
   logic [Addres_depth-1:0] sel_a;
   logic [DataWidth-1:0]    sel_d;

   // ptr_q = 1 favours requester 1 on contention.
   // The clear's first write is loaded on the edge that enters CLEAR,
   // and cnt_q tracks the address currently on A3 while clearing.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      a_d     = a_q;
      wd_d    = wd_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      busy    = 1'b0;
      sel_a   = addr1;
      sel_d   = data1;
      unique case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
               we_d    = 1'b1;
               a_d     = '0;
               wd_d    = '0;
            end else begin
               gnt0 = req0 & (~req1 | ~ptr_q);
               gnt1 = req1 & ~gnt0;
               if (gnt0) begin
                  sel_a = addr0;
                  sel_d = data0;
               end
               if (gnt0 | gnt1) begin
                  ptr_d = gnt0;
                  // Guarded writes to x0 are consumed silently.
                  if (!(ZeroGuard && sel_a == '0)) begin
                     we_d = 1'b1;
                     a_d  = sel_a;
                     wd_d = sel_d;
                  end
               end
            end
         end
         CLEAR: begin
            busy = 1'b1;
            if (cnt_q == LastAddr) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               we_d  = 1'b1;
               a_d   = cnt_q + 1'b1;
               wd_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         a_q     <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         a_q     <= a_d;
         wd_q    <= wd_d;
      end
   end

   assign WE3 = we_q;
   assign A3  = a_q;
   assign WD3 = wd_q;

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port controller for the 32x32 register file in the multicycle core. Shares the single register-file write port (WE3/A3/WD3) between two requesters with a req/gnt handshake and round-robin arbitration. Also runs a clear sequencer that walks every address writing zero. Sits between the writeback sources and the register file and drives its write inputs directly.

## Interface
- DataWidth, 32, width of write data
- Depth, 32, number of registers; clear walks addresses 0..Depth-1
- Addres_depth, 5, address width; Depth <= 2^Addres_depth
- ZeroGuard, 1, when 1 an accepted write to address 0 is consumed but not issued (WE3 stays 0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 write request; held with addr0/data0 stable until granted
- addr0  in  Addres_depth  requester 0 target register
- data0  in  DataWidth  requester 0 write data
- gnt0  out  1  combinational grant; transfer when req0 & gnt0 at rising edge
- req1, addr1, data1, gnt1  same as requester 0, for requester 1
- clr_start  in  1  single-cycle pulse requesting a full clear
- busy  out  1  high while the clear sequence owns the write port
- WE3  out  1  registered write enable to register file
- A3  out  Addres_depth  registered write address
- WD3  out  DataWidth  registered write data

## Operation
- States: IDLE, CLEAR. Reset -> IDLE.
- IDLE, clr_start=0: arbitrate.
  - Only one req high: grant it.
  - Both high: grant the side named by the priority pointer.
  - After any grant to side k, the pointer moves to the other side. Reset value favours requester 0.
  - At most one gnt high per cycle. gnt is never high without its req.
- IDLE, clr_start=1: no grant that cycle. Clear has priority over both requesters. Next state is CLEAR.
- CLEAR: gnt0=gnt1=0, busy=1.
  - Issues Depth writes, WD3=0, addresses 0,1,...,Depth-1 on consecutive cycles.
  - Returns to IDLE after the write to address Depth-1.
  - clr_start is ignored while in CLEAR.
  - The priority pointer is unchanged by a clear.
- Granted transfer: at the edge, the output stage loads WE3=1, A3=addr, WD3=data.
  - With ZeroGuard=1 and addr=0, it loads WE3=0 instead; the requester still sees the grant.
- Cycles with no transfer and not in CLEAR: WE3 loads 0. A3/WD3 hold their last values.

## Timing
- Reset values: WE3=0, A3=0, WD3=0, busy=0, gnt0=gnt1=0, state IDLE, pointer=0, clear counter=0.
- Reset asserted mid-clear aborts the clear immediately. Outputs go to reset values; no further clear writes.
- Write latency: a transfer accepted at edge n produces WE3=1 during cycle n+1. The register file captures the data at edge n+1.
- Peak throughput: one write per cycle. Back-to-back grants give back-to-back WE3 pulses.
- Clear timing, with clr_start high in IDLE cycle t:
  - busy=1 for exactly Depth cycles, t+1..t+Depth.
  - During cycle t+1+k: WE3=1, A3=k, WD3=0.
  - Cycle t+Depth+1: busy=0, WE3=0, grants allowed again.
  - First requester write after the clear appears in cycle t+Depth+2 or later.
- A write granted at cycle t-1 issues in cycle t, before the clear starts; it is never lost or overwritten out of order.
- The requester holds req asserted while the port is busy. Dropping req before the grant withdraws the request without side effect.

## Test plan
- Reset then idle: hold rst=0, release. Expect all outputs 0. req0=1, addr0=5, data0=0xDEADBEEF -> gnt0=1 same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
- Contention: req0 and req1 both held high for 4 cycles with distinct addrs 3 and 7. Expect grants 0,1,0,1 and WE3 addresses 3,7,3,7 one cycle later.
- Zero guard: req1=1, addr1=0, data1=0x1234. Expect gnt1=1 and WE3=0 the next cycle. With ZeroGuard=0, expect WE3=1, A3=0.
- Clear: pulse clr_start with req0 held high. Expect busy high for 32 cycles; WE3=1 with A3=0..31 and WD3=0; gnt0=0 throughout. gnt0=1 in the first cycle after busy falls.
- Reset mid-clear: assert rst during the clear at A3=10. Expect busy=0 and WE3=0 immediately, state IDLE after release, and no further clear writes.
- clr_start during CLEAR: a second pulse at cycle t+5 has no effect. busy still falls after cycle t+32.
